bcd_timekeeper: RTL

Time-of-day counter that consumes the single-cycle rollover tick produced by the mod-k counter stage. It accumulates hours, minutes and seconds in packed BCD for the seven-segment display stage. It also provides a three-state set mode driven by two push-buttons, plus a per-field blink indication. It sits between the 1 Hz tick generator and the HEX display decoders in the DE10-Lite top level.

---
 rtl/bcd_timekeeper_if.sv | 34 +++
 rtl/bcd_timekeeper.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timekeeper_if.sv
// Bundle of the timekeeper's tick/key inputs and BCD display outputs.
//   tick        : one-cycle pulse per second from the upstream mod-k counter
//   key_mode_n  : raw active-low mode push-button (asynchronous to clk)
//   key_inc_n   : raw active-low increment push-button (asynchronous to clk)
//   hour_bcd    : two BCD digits of hours
//   min_bcd     : two BCD digits of minutes
//   sec_bcd     : two BCD digits of seconds
//   pm          : PM flag (only meaningful in 12-hour builds)
//   blink_hour  : blank request for the hour field while it is being set
//   blink_min   : blank request for the minute field while it is being set
//   day_tick    : one-cycle pulse on each day rollover
// The master modport is the stimulus/producer side, the slave modport is the timekeeper.
interface bcd_timekeeper_if;
    logic       tick;
    logic       key_mode_n;
    logic       key_inc_n;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       pm;
    logic       blink_hour;
    logic       blink_min;
    logic       day_tick;

    modport master (
        output tick, key_mode_n, key_inc_n,
        input  hour_bcd, min_bcd, sec_bcd, pm, blink_hour, blink_min, day_tick
    );

    modport slave (
        input  tick, key_mode_n, key_inc_n,
        output hour_bcd, min_bcd, sec_bcd, pm, blink_hour, blink_min, day_tick
    );
endinterface

// File: rtl/bcd_timekeeper.sv
// Packed-BCD time-of-day counter with a push-button set mode.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : bcd_timekeeper_if.slave (tick and key inputs, BCD/blink/day outputs)
// Configuration macro: TIMEKEEPER_12H_EN selects 12-hour operation with a live pm
// flag (hours 12,01..11); when undefined the block counts 00..23 and pm stays 0.
// Modes: RUN counts seconds on tick; SET_HOUR / SET_MIN let the inc key step the
// selected field without carry while tick only toggles the blink phase.
module bcd_timekeeper (
    input  logic            clk,
    input  logic            reset_n,
    bcd_timekeeper_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

`ifdef TIMEKEEPER_12H_EN
    localparam logic [7:0] HOUR_RESET = 8'h12;
    localparam logic [7:0] HOUR_LAST  = 8'h12;   // 12 -> 01
    localparam logic [7:0] HOUR_FIRST = 8'h01;
`else
    localparam logic [7:0] HOUR_RESET = 8'h00;
    localparam logic [7:0] HOUR_LAST  = 8'h23;   // 23 -> 00
    localparam logic [7:0] HOUR_FIRST = 8'h00;
`endif

    // Digit-wise BCD increment: returns {wrapped, next}. Reaching max_v wraps to
    // wrap_v; otherwise ones 9 -> 0 bumps the tens digit.
    function automatic logic [8:0] bcd_inc_wrap(input logic [7:0] v,
                                                input logic [7:0] max_v,
                                                input logic [7:0] wrap_v);
        logic [8:0] r;
        if (v == max_v) begin
            r = {1'b1, wrap_v};
        end else if (v[3:0] == 4'd9) begin
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Key path: [0],[1] synchronizer, [2] previous-sample register.
    logic [2:0] mode_sync_r;
    logic [2:0] inc_sync_r;
    logic       mode_act_r;
    logic       inc_act_r;

    state_t     state_r, state_nxt;
    logic [7:0] hour_r, hour_nxt;
    logic [7:0] min_r, min_nxt;
    logic [7:0] sec_r, sec_nxt;
    logic       pm_r, pm_nxt;
    logic       phase_r, phase_nxt;
    logic       day_nxt;
    logic       day_tick_r;
    logic       blink_hour_r;
    logic       blink_min_r;

    logic [8:0] sec_inc_s;
    logic [8:0] min_inc_s;
    logic [8:0] hour_inc_s;

    assign sec_inc_s  = bcd_inc_wrap(sec_r, 8'h59, 8'h00);
    assign min_inc_s  = bcd_inc_wrap(min_r, 8'h59, 8'h00);
    assign hour_inc_s = bcd_inc_wrap(hour_r, HOUR_LAST, HOUR_FIRST);

    // Synchronize both keys and register a one-cycle pulse per falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_sync_r <= 3'b111;
            inc_sync_r  <= 3'b111;
            mode_act_r  <= 1'b0;
            inc_act_r   <= 1'b0;
        end else begin
            mode_sync_r <= {mode_sync_r[1:0], bus.key_mode_n};
            inc_sync_r  <= {inc_sync_r[1:0], bus.key_inc_n};
            mode_act_r  <= mode_sync_r[2] & ~mode_sync_r[1];
            inc_act_r   <= inc_sync_r[2] & ~inc_sync_r[1];
        end
    end

    // Next-state logic for mode, time fields, pm, blink phase and day pulse.
    always_comb begin
        state_nxt = state_r;
        hour_nxt  = hour_r;
        min_nxt   = min_r;
        sec_nxt   = sec_r;
        pm_nxt    = pm_r;
        phase_nxt = phase_r;
        day_nxt   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (bus.tick) begin
                    sec_nxt = sec_inc_s[7:0];
                    if (sec_inc_s[8]) begin
                        min_nxt = min_inc_s[7:0];
                        if (min_inc_s[8]) begin
                            hour_nxt = hour_inc_s[7:0];
`ifdef TIMEKEEPER_12H_EN
                            // 11:59:59 -> 12:00:00 flips pm; leaving pm ends the day.
                            if (hour_r == 8'h11) begin
                                pm_nxt  = ~pm_r;
                                day_nxt = pm_r;
                            end else begin
                                pm_nxt  = pm_r;
                            end
`else
                            day_nxt = hour_inc_s[8];
`endif
                        end else begin
                            hour_nxt = hour_r;
                        end
                    end else begin
                        min_nxt = min_r;
                    end
                end else begin
                    sec_nxt = sec_r;
                end
                // Mode entry overrides the tick's seconds update.
                if (mode_act_r) begin
                    state_nxt = ST_SET_HOUR;
                    sec_nxt   = 8'h00;
                    phase_nxt = 1'b0;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_SET_HOUR: begin
                sec_nxt = 8'h00;
                if (mode_act_r) begin
                    state_nxt = ST_SET_MIN;
                    phase_nxt = 1'b0;
                end else begin
                    phase_nxt = bus.tick ? ~phase_r : phase_r;
                    if (inc_act_r) begin
                        hour_nxt = hour_inc_s[7:0];
`ifdef TIMEKEEPER_12H_EN
                        if (hour_r == 8'h11) begin
                            pm_nxt = ~pm_r;
                        end else begin
                            pm_nxt = pm_r;
                        end
`endif
                    end else begin
                        hour_nxt = hour_r;
                    end
                end
            end
            ST_SET_MIN: begin
                sec_nxt = 8'h00;
                if (mode_act_r) begin
                    state_nxt = ST_RUN;
                    phase_nxt = 1'b0;
                end else begin
                    phase_nxt = bus.tick ? ~phase_r : phase_r;
                    if (inc_act_r) begin
                        min_nxt = min_inc_s[7:0];
                    end else begin
                        min_nxt = min_r;
                    end
                end
            end
            default: begin
                state_nxt = ST_RUN;
                phase_nxt = 1'b0;
            end
        endcase
    end

    // Time state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_RUN;
            hour_r       <= HOUR_RESET;
            min_r        <= 8'h00;
            sec_r        <= 8'h00;
            pm_r         <= 1'b0;
            phase_r      <= 1'b0;
            day_tick_r   <= 1'b0;
            blink_hour_r <= 1'b0;
            blink_min_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            hour_r       <= hour_nxt;
            min_r        <= min_nxt;
            sec_r        <= sec_nxt;
            pm_r         <= pm_nxt;
            phase_r      <= phase_nxt;
            day_tick_r   <= day_nxt;
            blink_hour_r <= phase_nxt & (state_nxt == ST_SET_HOUR);
            blink_min_r  <= phase_nxt & (state_nxt == ST_SET_MIN);
        end
    end

    assign bus.hour_bcd   = hour_r;
    assign bus.min_bcd    = min_r;
    assign bus.sec_bcd    = sec_r;
    assign bus.pm         = pm_r;
    assign bus.blink_hour = blink_hour_r;
    assign bus.blink_min  = blink_min_r;
    assign bus.day_tick   = day_tick_r;

endmodule
